// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner: FSM states, column
// reset pattern, KB field layout and the auto-repeat timing.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  localparam logic [3:0] COL_RESET = 4'b1110;

  localparam int KB_PRESSED_BIT = 7;
  localparam int KB_CODE_MSB    = 3;
  localparam int KB_CODE_LSB    = 0;

  localparam int REPEAT_START  = 32;
  localparam int REPEAT_PERIOD = 8;

  // Rows are active-low; the lowest-numbered low row wins when several are low.
  function automatic logic [1:0] lowest_low_row(input logic [3:0] rows);
    logic [1:0] idx;
    idx = 2'd3;
    if (!rows[0])      idx = 2'd0;
    else if (!rows[1]) idx = 2'd1;
    else if (!rows[2]) idx = 2'd2;
    return idx;
  endfunction

  function automatic logic [1:0] col_index(input logic [3:0] col);
    logic [1:0] idx;
    case (col)
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  function automatic logic [7:0] kb_word(input logic pressed, input logic [3:0] code);
    logic [7:0] w;
    w = '0;
    w[KB_PRESSED_BIT] = pressed;
    w[KB_CODE_MSB:KB_CODE_LSB] = code;
    return w;
  endfunction

  // Repeat fires at the first threshold, then the counter folds back so the
  // second threshold recurs every period.
  function automatic logic repeat_due(input logic [5:0] held_slots);
    return (held_slots == 6'(REPEAT_START)) ||
           (held_slots == 6'(REPEAT_START + REPEAT_PERIOD));
  endfunction

endpackage

// File: rtl/keypad_slot_timer.sv
// Free-running slot timer: counts 0..SCAN_DIV-1 and flags the final cycle of
// each slot, which is both the row-sample point and the rollover event.
module keypad_slot_timer #(
  parameter int SCAN_DIV = 1000
) (
  input  logic clk,
  input  logic rst,
  output logic slot_end,
  output logic slot_wrap
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign slot_end  = (count == LAST);
  assign slot_wrap = (count == LAST);

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with press/release debounce and a KB word for the
// mcu. Define KEYPAD_REPEAT_EN to add auto-repeat strobes while a key is held.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [7:0] KB,
  output logic       key_strobe
);

  localparam int CNT_W = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CNT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [3:0]       sync1;
  logic [3:0]       sync2;
  logic             slot_end;
  logic             slot_wrap;
  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0] cnt_inc;
  logic [3:0]       code;
  logic [3:0]       code_next;
  logic [3:0]       hit_code;
  logic [3:0]       col_next;
  logic [3:0]       col_rot;
  logic [7:0]       kb_next;
  logic             strobe_next;
  logic             strobe_all;
  logic             any_low;
  logic             row_match;
  logic             cand_high;

  keypad_slot_timer #(
    .SCAN_DIV(SCAN_DIV)
  ) u_slot_timer (
    .clk      (clk),
    .rst      (rst),
    .slot_end (slot_end),
    .slot_wrap(slot_wrap)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= row_in;
      sync2 <= sync1;
    end
  end

  assign any_low   = (sync2 != 4'hF);
  assign hit_code  = {col_index(col_out), lowest_low_row(sync2)};
  assign row_match = any_low && (hit_code[1:0] == code[1:0]);
  assign cand_high = sync2[code[1:0]];
  assign cnt_inc   = cnt + 1'b1;
  assign col_rot   = {col_out[2:0], col_out[3]};

  // The column only moves while scanning or when a release completes; every
  // other state keeps it frozen on the candidate key's column.
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    code_next   = code;
    col_next    = col_out;
    kb_next     = KB;
    strobe_next = 1'b0;
    if (slot_end) begin
      unique case (state)
        SCAN: begin
          if (any_low) begin
            code_next = hit_code;
            if (DEBOUNCE_CNT == 1) begin
              state_next  = HELD;
              cnt_next    = '0;
              kb_next     = kb_word(1'b1, hit_code);
              strobe_next = 1'b1;
            end else begin
              state_next = DEBOUNCE;
              cnt_next   = CNT_ONE;
            end
          end else if (slot_wrap) begin
            col_next = col_rot;
          end
        end
        DEBOUNCE: begin
          if (row_match) begin
            if (cnt_inc == CNT_DONE) begin
              state_next  = HELD;
              cnt_next    = '0;
              kb_next     = kb_word(1'b1, code);
              strobe_next = 1'b1;
            end else begin
              cnt_next = cnt_inc;
            end
          end else begin
            state_next = SCAN;
            cnt_next   = '0;
          end
        end
        HELD: begin
          if (cand_high) begin
            if (DEBOUNCE_CNT == 1) begin
              state_next              = SCAN;
              cnt_next                = '0;
              kb_next[KB_PRESSED_BIT] = 1'b0;
              if (slot_wrap) col_next = col_rot;
            end else begin
              state_next = RELEASE;
              cnt_next   = CNT_ONE;
            end
          end
        end
        RELEASE: begin
          if (cand_high) begin
            if (cnt_inc == CNT_DONE) begin
              state_next              = SCAN;
              cnt_next                = '0;
              kb_next[KB_PRESSED_BIT] = 1'b0;
              if (slot_wrap) col_next = col_rot;
            end else begin
              cnt_next = cnt_inc;
            end
          end else begin
            state_next = HELD;
            cnt_next   = '0;
          end
        end
        default: begin
          state_next = SCAN;
          cnt_next   = '0;
        end
      endcase
    end
  end

`ifdef KEYPAD_REPEAT_EN
  logic [5:0] rep_cnt;
  logic [5:0] rep_next;
  logic [5:0] rep_inc;
  logic       rep_fire;

  localparam logic [5:0] REP_FIRST = 6'(REPEAT_START);
  localparam logic [5:0] REP_WRAP  = 6'(REPEAT_START + REPEAT_PERIOD);

  // Slots spent continuously in HELD; any exit or fresh entry restarts the run.
  always_comb begin
    rep_inc  = rep_cnt + 1'b1;
    rep_next = rep_cnt;
    rep_fire = 1'b0;
    if (state != HELD || state_next != HELD) begin
      rep_next = '0;
    end else if (slot_wrap) begin
      rep_fire = repeat_due(rep_inc);
      rep_next = (rep_inc == REP_WRAP) ? REP_FIRST : rep_inc;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rep_cnt <= '0;
    end else begin
      rep_cnt <= rep_next;
    end
  end

  assign strobe_all = strobe_next | rep_fire;
`else
  assign strobe_all = strobe_next;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= SCAN;
      cnt        <= '0;
      code       <= '0;
      col_out    <= COL_RESET;
      KB         <= '0;
      key_strobe <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      code       <= code_next;
      col_out    <= col_next;
      KB         <= kb_next;
      key_strobe <= strobe_all;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: a simulated key matrix drives the
// rows and a slot-level reference model predicts columns, KB and strobes.
`timescale 1ns/1ps
module tb_keypad_scanner;

  localparam int SCAN_DIV     = 4;
  localparam int DEBOUNCE_CNT = 3;
`ifdef KEYPAD_REPEAT_EN
  localparam int REPEAT_EXTRA = 5;
`else
  localparam int REPEAT_EXTRA = 0;
`endif

  localparam int IDLE    = 0;
  localparam int CONFIRM = 1;
  localparam int HOLDING = 2;
  localparam int LETGO   = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [7:0] KB;
  logic       key_strobe;
  logic [15:0] keys = '0;

  int checks = 0;
  int errors = 0;
  int strobe_seen = 0;
  int strobe_exp = 0;

  int         m_col, m_phase, m_cand, m_hits, m_rel, m_held_slots;
  logic [7:0] m_kb;
  logic       m_strobe;

  always #5 clk = ~clk;

  keypad_scanner #(
    .SCAN_DIV    (SCAN_DIV),
    .DEBOUNCE_CNT(DEBOUNCE_CNT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .row_in    (row_in),
    .col_out   (col_out),
    .KB        (KB),
    .key_strobe(key_strobe)
  );

  // Key index = col*4 + row; a pressed key pulls its row low while its column is driven.
  always_comb begin
    row_in = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (!col_out[c] && keys[c*4+r]) row_in[r] = 1'b0;
  end

  always @(negedge clk) if (rst && key_strobe) strobe_seen++;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, want);
    end
  endtask

  function automatic int lowestPressed(input logic [3:0] low);
    for (int r = 0; r < 4; r++) if (low[r]) return r;
    return -1;
  endfunction

  task automatic modelReset();
    m_col = 0; m_phase = IDLE; m_cand = 0; m_hits = 0; m_rel = 0;
    m_held_slots = 0; m_kb = 8'h00; m_strobe = 1'b0;
  endtask

  task automatic modelAccept();
    m_phase = HOLDING;
    m_kb = {1'b1, 3'b000, 4'(m_cand)};
    m_strobe = 1'b1;
    strobe_exp++;
    m_held_slots = 0;
  endtask

  task automatic modelLetGo();
    m_kb = m_kb & 8'h7F;
    m_phase = IDLE;
    m_hits = 0;
    m_col = (m_col + 1) % 4;
  endtask

  // One row sample at the end of a slot, expressed in terms of keys and columns.
  task automatic modelSlot();
    logic [3:0] low;
    int r;
    low = keys[m_col*4 +: 4];
    r = lowestPressed(low);
    m_strobe = 1'b0;
    case (m_phase)
      IDLE: begin
        if (r >= 0) begin
          m_cand = m_col*4 + r;
          m_hits = 1;
          if (m_hits >= DEBOUNCE_CNT) modelAccept();
          else m_phase = CONFIRM;
        end else begin
          m_col = (m_col + 1) % 4;
        end
      end
      CONFIRM: begin
        if (r == m_cand % 4) begin
          m_hits++;
          if (m_hits >= DEBOUNCE_CNT) modelAccept();
        end else begin
          m_phase = IDLE;
          m_hits = 0;
        end
      end
      HOLDING: begin
        if (!low[m_cand % 4]) begin
          m_rel = 1;
          if (m_rel >= DEBOUNCE_CNT) modelLetGo();
          else m_phase = LETGO;
        end else begin
          m_held_slots++;
`ifdef KEYPAD_REPEAT_EN
          if (m_held_slots >= 32 && (m_held_slots - 32) % 8 == 0) begin
            m_strobe = 1'b1;
            strobe_exp++;
          end
`endif
        end
      end
      default: begin
        if (!low[m_cand % 4]) begin
          m_rel++;
          if (m_rel >= DEBOUNCE_CNT) modelLetGo();
        end else begin
          m_phase = HOLDING;
          m_held_slots = 0;
        end
      end
    endcase
  endtask

  task automatic applyStimulus(input logic [15:0] k, input int nslots);
    logic [3:0] exp_col;
    for (int i = 0; i < nslots; i++) begin
      keys = k;
      repeat (SCAN_DIV) @(posedge clk);
      modelSlot();
      @(negedge clk);
      #1;
      exp_col = ~(4'b0001 << m_col);
      checkOutput("col_out", {28'd0, col_out}, {28'd0, exp_col});
      checkOutput("KB", {24'd0, KB}, {24'd0, m_kb});
      checkOutput("key_strobe", {31'd0, key_strobe}, {31'd0, m_strobe});
    end
  endtask

  task automatic applyReset(input string tag);
    rst = 1'b0;
    #1;
    checkOutput({tag, "_kb"}, {24'd0, KB}, 32'h00);
    checkOutput({tag, "_col"}, {28'd0, col_out}, 32'hE);
    checkOutput({tag, "_strobe"}, {31'd0, key_strobe}, 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    modelReset();
  endtask

  initial begin
    int snap;
    logic seen;
    logic [15:0] mask;
    int len;
    int sel;

    modelReset();
    repeat (2) @(negedge clk);
    applyReset("reset");

    snap = strobe_seen;
    applyStimulus(16'h0040, 8);
    checkOutput("press_kb", {24'd0, KB}, 32'h86);
    applyStimulus(16'h0000, 4);
    checkOutput("release_kb", {24'd0, KB}, 32'h06);
    checkOutput("press_strobes", strobe_seen - snap, 1);

    applyStimulus(16'h000A, 8);
    checkOutput("multirow_kb", {24'd0, KB}, 32'h81);
    applyStimulus(16'h0000, 4);

    snap = strobe_seen;
    for (int i = 0; i < 10; i++) applyStimulus((i % 2 == 0) ? 16'h0040 : 16'h0000, 1);
    checkOutput("bounce_strobes", strobe_seen - snap, 0);
    applyStimulus(16'h0040, 12);
    checkOutput("settle_strobes", strobe_seen - snap, 1);
    checkOutput("settle_kb", {24'd0, KB}, 32'h86);
    applyStimulus(16'h0000, 4);

    applyStimulus(16'h0040, 8);
    snap = strobe_seen;
    applyStimulus(16'h0000, 1);
    applyStimulus(16'h0040, 3);
    checkOutput("glitch_pressed", {31'd0, KB[7]}, 32'h1);
    checkOutput("glitch_strobes", strobe_seen - snap, 0);
    applyStimulus(16'h0000, 4);

    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      applyStimulus(16'h0040, 1);
      seen = key_strobe;
    end
    checkOutput("hold_entry", {31'd0, seen}, 32'h1);
    snap = strobe_seen;
    applyStimulus(16'h0040, 64);
    checkOutput("hold_repeats", strobe_seen - snap, REPEAT_EXTRA);
    applyStimulus(16'h0000, 4);

    for (int i = 0; i < 8 && m_phase != CONFIRM; i++) applyStimulus(16'h0040, 1);
    applyReset("midpress");
    snap = strobe_seen;
    applyStimulus(16'h0040, 8);
    checkOutput("redetect_strobes", strobe_seen - snap, 1);
    applyStimulus(16'h0000, 4);

    for (int seg = 0; seg < 60; seg++) begin
      sel = $urandom_range(0, 99);
      mask = '0;
      if (sel >= 35) mask[$urandom_range(0, 15)] = 1'b1;
      if (sel >= 85) mask[$urandom_range(0, 15)] = 1'b1;
      len = $urandom_range(1, 12);
      applyStimulus(mask, len);
    end

    checkOutput("strobe_total", strobe_seen, strobe_exp);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
